// File: rtl/uart_apb_master.sv
// UART-driven APB initiator: parses 0x57/0x52 command frames, runs one APB transfer, returns status (+ read data) bytes.
// Define UART_APB_TIMEOUT_EN to abort ACCESS after APB_TIMEOUT cycles without PREADY (status 0x02).
module uart_apb_master #(
  parameter int RX_TIMEOUT  = 100000,
  parameter int APB_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_done_i,
  output logic        PSEL_o,
  output logic        PENABLE_o,
  output logic        PWRITE_o,
  output logic [31:0] PADDR_o,
  output logic [31:0] PWDATA_o,
  input  logic [31:0] PRDATA_i,
  input  logic        PREADY_i,
  input  logic        PSLVERR_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] OP_WR     = 8'h57;
  localparam logic [7:0] OP_RD     = 8'h52;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_SLVERR = 8'h01;
  localparam logic [7:0] ST_TMO    = 8'h02;
  localparam logic [7:0] ST_BADOP  = 8'h03;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] rx_timer;
  logic [7:0]  status;
  logic [31:0] rdata;
  logic [2:0]  tx_idx;
  logic [2:0]  tx_last;
  logic        tx_valid;
  logic        rx_expired;
  logic        tx_last_done;
  logic        apb_expired;

  // An arriving byte always beats a simultaneous timer expiry.
  assign rx_expired   = !rx_valid_i && (rx_timer == 32'(RX_TIMEOUT - 1));
  assign tx_last      = (PWRITE_o || status == ST_BADOP) ? 3'd0 : 3'd4;
  assign tx_last_done = tx_valid && tx_done_i && (tx_idx == tx_last);
  assign tx_valid_o   = tx_valid;

`ifdef UART_APB_TIMEOUT_EN
  logic [31:0] apb_timer;

  assign apb_expired = !PREADY_i && (apb_timer == 32'(APB_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                apb_timer <= 32'd0;
    else if (state != ACCESS) apb_timer <= 32'd0;
    else                      apb_timer <= apb_timer + 32'd1;
  end
`else
  assign apb_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (rx_valid_i)
          state_nxt = (rx_data_i == OP_WR || rx_data_i == OP_RD) ? ADDR : RESP;
      ADDR:
        if (rx_valid_i && byte_cnt == 2'd3) state_nxt = PWRITE_o ? WDATA : SETUP;
        else if (rx_expired)                state_nxt = IDLE;
      WDATA:
        if (rx_valid_i && byte_cnt == 2'd3) state_nxt = SETUP;
        else if (rx_expired)                state_nxt = IDLE;
      SETUP:  state_nxt = ACCESS;
      ACCESS:
        if (PREADY_i || apb_expired) state_nxt = RESP;
      RESP:
        if (tx_last_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PSEL_o    = (state == SETUP) || (state == ACCESS);
    PENABLE_o = (state == ACCESS);
    busy_o    = !(state == IDLE || state == ADDR || state == WDATA);
    case (tx_idx)
      3'd1:    tx_data_o = rdata[7:0];
      3'd2:    tx_data_o = rdata[15:8];
      3'd3:    tx_data_o = rdata[23:16];
      3'd4:    tx_data_o = rdata[31:24];
      default: tx_data_o = status;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= 2'd0;
      rx_timer <= 32'd0;
      PWRITE_o <= 1'b0;
      PADDR_o  <= 32'd0;
      PWDATA_o <= 32'd0;
      status   <= ST_OK;
      rdata    <= 32'd0;
      tx_idx   <= 3'd0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          byte_cnt <= 2'd0;
          rx_timer <= 32'd0;
          if (rx_valid_i) begin
            if (rx_data_i == OP_WR || rx_data_i == OP_RD) PWRITE_o <= (rx_data_i == OP_WR);
            else                                          status   <= ST_BADOP;
          end
        end
        ADDR, WDATA: begin
          if (rx_valid_i) begin
            rx_timer <= 32'd0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ADDR) PADDR_o[{byte_cnt, 3'b000} +: 8]  <= rx_data_i;
            else               PWDATA_o[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
          end else begin
            rx_timer <= rx_timer + 32'd1;
          end
        end
        ACCESS: begin
          if (PREADY_i) begin
            status <= PSLVERR_i ? ST_SLVERR : ST_OK;
            if (!PWRITE_o) rdata <= PRDATA_i;
          end else if (apb_expired) begin
            status <= ST_TMO;
            rdata  <= 32'd0;
          end
        end
        RESP: begin
          // Drop valid for one cycle after each done, then present the next byte.
          if (!tx_valid) begin
            tx_valid <= 1'b1;
          end else if (tx_done_i) begin
            tx_valid <= 1'b0;
            tx_idx   <= tx_idx + 3'd1;
          end
        end
        default: ;
      endcase
      if (state != RESP && state_nxt == RESP) begin
        tx_valid <= 1'b1;
        tx_idx   <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: host byte driver, APB slave with wait states, tx host with done pulses.
`timescale 1ns/1ps
module tb_uart_apb_master;
  localparam int RXT  = 40;
  localparam int APBT = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_done_i = 1'b0;
  logic        PSEL_o, PENABLE_o, PWRITE_o, busy_o;
  logic [31:0] PADDR_o, PWDATA_o;
  logic [31:0] PRDATA_i = 32'h0;
  logic        PREADY_i = 1'b0;
  logic        PSLVERR_i = 1'b0;

  uart_apb_master #(.RX_TIMEOUT(RXT), .APB_TIMEOUT(APBT)) dut (
    .clk(clk), .rstn(rstn),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_done_i(tx_done_i),
    .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
    .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o), .PRDATA_i(PRDATA_i),
    .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wait_states = 0;
  bit stuck = 1'b0;
  bit dbl_done = 1'b0;
  int psel_cnt = 0;
  int setup_cnt = 0;
  int acc_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // APB slave: PREADY asserted after wait_states ACCESS cycles unless stuck.
  always @(negedge clk) begin
    if (PSEL_o) psel_cnt++;
    if (PSEL_o && !PENABLE_o) setup_cnt++;
    if (PSEL_o && PENABLE_o) begin
      PREADY_i = !stuck && (acc_n >= wait_states);
      acc_n++;
    end else begin
      PREADY_i = 1'b0;
      acc_n = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Byte i of the expected response is exp[8*i +: 8].
  task automatic expect_resp(input string tag, input int n, input logic [39:0] exp);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!tx_valid_o && t < 100) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("%s_vld%0d", tag, i), tx_valid_o, 1);
      if (!tx_valid_o) return;
      check($sformatf("%s_b%0d", tag, i), tx_data_o, exp[8*i +: 8]);
      tx_done_i = 1'b1;
      @(negedge clk);
      tx_done_i = dbl_done;
      check($sformatf("%s_gap%0d", tag, i), tx_valid_o, 0);
      if (i == n - 1) check($sformatf("%s_idle", tag), busy_o, 0);
      @(negedge clk);
      tx_done_i = 1'b0;
      check($sformatf("%s_next%0d", tag, i), tx_valid_o, (i < n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctl", {PSEL_o, PENABLE_o, PWRITE_o, busy_o, tx_valid_o}, 0);
    check("rst_paddr", PADDR_o, 0);
    check("rst_pwdata", PWDATA_o, 0);
    check("rst_txdata", tx_data_o, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Write, zero wait states: exact SETUP/ACCESS latency.
    psel_cnt = 0; setup_cnt = 0; wait_states = 0;
    send_byte(8'h57); send_word(32'h40000010); send_word(32'hDEADBEEF);
    check("wr_setup", {PSEL_o, PENABLE_o}, 2'b10);
    check("wr_busy", busy_o, 1);
    @(negedge clk);
    check("wr_access", {PSEL_o, PENABLE_o}, 2'b11);
    check("wr_paddr", PADDR_o, 32'h40000010);
    check("wr_pwdata", PWDATA_o, 32'hDEADBEEF);
    check("wr_pwrite", PWRITE_o, 1);
    expect_resp("wr", 1, 40'h00);
    check("wr_psel_cyc", psel_cnt, 2);
    check("wr_setup_cyc", setup_cnt, 1);

    // Read with 3 wait states; done also held during gaps (must be ignored).
    psel_cnt = 0; wait_states = 3; PRDATA_i = 32'h12345678; dbl_done = 1'b1;
    send_byte(8'h52); send_word(32'h40000004);
    expect_resp("rd", 5, 40'h1234567800);
    check("rd_psel_cyc", psel_cnt, 5);
    check("rd_paddr", PADDR_o, 32'h40000004);
    check("rd_pwrite", PWRITE_o, 0);
    dbl_done = 1'b0;

    // Slave error on write.
    wait_states = 0; PSLVERR_i = 1'b1;
    send_byte(8'h57); send_word(32'h50000020); send_word(32'h11223344);
    expect_resp("slverr", 1, 40'h01);
    check("slverr_pwdata", PWDATA_o, 32'h11223344);
    PSLVERR_i = 1'b0;

    // Bad opcode: status only, no APB activity.
    psel_cnt = 0;
    send_byte(8'hAA);
    expect_resp("badop", 1, 40'h03);
    check("badop_psel_cyc", psel_cnt, 0);

    // Partial frame abandoned by the inter-byte timeout.
    psel_cnt = 0;
    send_byte(8'h52); send_byte(8'h04); send_byte(8'h00);
    repeat (RXT + 5) @(negedge clk);
    check("abort_txvld", tx_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_psel_cyc", psel_cnt, 0);
    check("abort_paddr_partial", PADDR_o, 32'h50000004);

    // Full read with an inter-byte gap just under the timeout.
    wait_states = 1; PRDATA_i = 32'hCAFEF00D;
    send_byte(8'h52); send_byte(8'h08);
    repeat (RXT - 2) @(negedge clk);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    expect_resp("rd2", 5, 40'hCAFEF00D00);
    check("rd2_paddr", PADDR_o, 32'h40000008);

    // Bytes arriving during ACCESS are dropped.
    wait_states = 6; PRDATA_i = 32'hA5A50F0F;
    send_byte(8'h52); send_word(32'h40000030);
    send_byte(8'h57); send_byte(8'h52);
    expect_resp("drop", 5, 40'hA5A50F0F00);
    repeat (10) @(negedge clk);
    check("drop_txvld", tx_valid_o, 0);
    check("drop_busy", busy_o, 0);
    check("drop_paddr", PADDR_o, 32'h40000030);

`ifdef UART_APB_TIMEOUT_EN
    // APB timeout with PREADY stuck low.
    psel_cnt = 0; stuck = 1'b1; PRDATA_i = 32'hFFFFFFFF;
    send_byte(8'h52); send_word(32'h40000040);
    expect_resp("apbtmo", 5, 40'h0000000002);
    check("apbtmo_psel_cyc", psel_cnt, 1 + APBT);
    stuck = 1'b0;
`endif

    // Asynchronous reset while in ACCESS.
    stuck = 1'b1;
    send_byte(8'h57); send_word(32'h60000000); send_word(32'h0BADF00D);
    repeat (3) @(negedge clk);
    check("arst_pre_access", PENABLE_o, 1);
    rstn = 1'b0;
    #1;
    check("arst_ctl", {PSEL_o, PENABLE_o, PWRITE_o, busy_o, tx_valid_o}, 0);
    check("arst_paddr", PADDR_o, 0);
    check("arst_pwdata", PWDATA_o, 0);
    @(negedge clk);
    rstn = 1'b1; stuck = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_no_resp", tx_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_apb_master.md
Name: uart_apb_master

Overview:
UART-driven APB initiator (debug bridge). It is the master-side counterpart to the APB-slave peripherals on the bus.
- Parses command frames from a byte stream produced by uart_rx.
- Issues single APB read/write transfers.
- Returns status and read data as a byte stream to uart_tx using the valid/done handshake.
- Lets a host PC read and write any APB register, including the UART peripheral's own registers.

Parameters:
RX_TIMEOUT, 100000, inter-byte timeout in clk cycles; a partial frame is discarded after this many cycles with no byte
APB_TIMEOUT, 1024, maximum cycles in ACCESS waiting for PREADY (used only with UART_APB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
rx_data_i  in  8  received byte, valid when rx_valid_i=1
rx_valid_i  in  1  single-cycle pulse per received byte
tx_data_o  out  8  byte to transmit
tx_valid_o  out  1  request transmit; held until tx_done_i
tx_done_i  in  1  single-cycle pulse, byte fully sent
PSEL_o  out  1  APB select
PENABLE_o  out  1  APB enable
PWRITE_o  out  1  APB direction, 1=write
PADDR_o  out  32  APB address
PWDATA_o  out  32  APB write data
PRDATA_i  in  32  APB read data
PREADY_i  in  1  APB ready
PSLVERR_i  in  1  APB slave error
busy_o  out  1  high in every state except IDLE, ADDR, WDATA

Behaviour:
- Reset: all outputs 0, state IDLE, byte counters 0, timers 0. Reset mid-frame or mid-transfer aborts immediately and sends no response.
- Frame format:
  - Write: opcode 0x57, 4 address bytes LSB first, 4 data bytes LSB first.
  - Read: opcode 0x52, 4 address bytes LSB first.
- States: IDLE, ADDR, WDATA, SETUP, ACCESS, RESP.
- IDLE:
  - Byte 0x57 or 0x52: latch PWRITE, go to ADDR with count=0.
  - Any other byte: latch status 0x03, go to RESP with 1 byte to send. No APB transfer.
- ADDR: each byte shifts into PADDR[8*count +: 8]. After byte 3, go to WDATA (write) or SETUP (read).
- WDATA: same shift into PWDATA. After byte 3, go to SETUP.
- Inter-byte timer (ADDR/WDATA only):
  - Clears on each rx_valid_i; increments otherwise.
  - On reaching RX_TIMEOUT: go to IDLE, no response, PADDR/PWDATA keep their partial values.
- Latency: last frame byte accepted in cycle N → SETUP in N+1 (PSEL=1, PENABLE=0) → ACCESS in N+2 (PSEL=1, PENABLE=1).
- ACCESS:
  - Hold all APB outputs until a cycle with PREADY_i=1.
  - In that cycle capture PRDATA_i (reads only) and PSLVERR_i.
  - Next cycle: PSEL=PENABLE=0, state RESP.
- PADDR_o, PWDATA_o, PWRITE_o are stable through SETUP and ACCESS and keep their last value otherwise.
- Status byte: 0x00 OK, 0x01 PSLVERR, 0x02 APB timeout, 0x03 bad opcode.
- RESP byte sequence:
  - Read: status, then PRDATA[7:0], [15:8], [23:16], [31:24]. Data bytes are sent even on error; the value is whatever was captured, 0 on timeout.
  - Write and bad opcode: status only.
- tx handshake:
  - tx_valid_o rises on RESP entry with tx_data_o = first byte.
  - On tx_done_i, tx_valid_o=0 for exactly one cycle, then the next byte is presented with tx_valid_o=1.
  - tx_done_i on the last byte → IDLE next cycle with tx_valid_o=0.
  - tx_done_i while tx_valid_o=0 is ignored.
- rx_valid_i during SETUP, ACCESS or RESP: byte dropped, no state change.
- Simultaneous rx_valid_i and timer expiry in ADDR/WDATA: the byte wins and the timer clears.
- Only whole-word transfers, with no PSTRB and no PPROT. The address is passed unmodified; alignment is not checked.

Optional Feature:
UART_APB_TIMEOUT_EN
- Defined:
  - A counter runs in ACCESS.
  - If PREADY_i is still low after APB_TIMEOUT cycles, drive PSEL=PENABLE=0 next cycle, set status 0x02 with captured data 0, and go to RESP.
- Undefined: no counter; ACCESS waits indefinitely for PREADY_i.

Test Plan:
- Write: bytes 57 10 00 00 40 EF BE AD DE, PREADY=1 → exactly one SETUP then one ACCESS with PADDR=0x40000010, PWDATA=0xDEADBEEF, PWRITE=1 → tx byte 0x00, then IDLE.
- Read with wait states: bytes 52 04 00 00 40, PREADY low 3 cycles then high with PRDATA=0x12345678 → PSEL high for 5 cycles total → tx 00 78 56 34 12, one-cycle tx_valid gap after each tx_done.
- Slave error: write with PSLVERR_i=1 in the ready cycle → tx 0x01.
- Bad opcode: byte 0xAA → tx 0x03, PSEL never asserted.
- Frame abort: 52 04 00, then idle RX_TIMEOUT cycles → no tx, IDLE. Then a full read frame executes normally. Separately, bytes injected during ACCESS are dropped.
- UART_APB_TIMEOUT_EN with APB_TIMEOUT=16 and PREADY stuck low → PSEL drops after 16 ACCESS cycles → tx 02 00 00 00 00. Also: rstn low during ACCESS → all outputs 0 immediately.
